// File: rtl/control_micro_mc.sv
// Multi-cycle microcontroller control unit: FETCH/DECODE/EXEC/MEM sequencing, datapath
// selects, register write strobe, data-memory handshake with timeout and the program counter.
module control_micro_mc #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned REG_BITS    = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3+2*REG_BITS-1:0] i_instruccion,
  input  logic                    i_instr_valid,
  input  logic [DATA_W-1:0]       Rx,
  input  logic [2:0]              Ban,
  input  logic                    i_mem_ack,
  output logic [2:0]              Sel_op,
  output logic [2*REG_BITS-1:0]   Sel_reg,
  output logic                    W,
  output logic [1:0]              Sel_outbus,
  output logic [2:0]              Sel_DW,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_W-1:0]       o_direccion_instruccion,
  output logic                    o_busy,
  output logic                    o_error
);

  localparam int unsigned IW   = 3 + 2 * REG_BITS;
  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(MEM_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PcRst   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StMem} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [2:0]      fn_q;
  logic [CntW-1:0] cnt_q;
  logic            taken;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = o_direccion_instruccion + ADDR_W'(1);

  // Jump condition over flags {N,C,Z}.
  always_comb begin
    taken = 1'b0;
    unique case (fn_q)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Ban[0];
      3'b010:  taken = ~Ban[0];
      3'b011:  taken = Ban[1];
      3'b100:  taken = ~Ban[1];
      3'b101:  taken = Ban[2];
      3'b110:  taken = ~Ban[2];
      3'b111:  taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                 <= StFetch;
      op_q                    <= '0;
      fn_q                    <= '0;
      cnt_q                   <= '0;
      o_direccion_instruccion <= PcRst;
      Sel_op                  <= '0;
      Sel_reg                 <= '0;
      W                       <= 1'b0;
      Sel_outbus              <= '0;
      Sel_DW                  <= '0;
      o_mem_req               <= 1'b0;
      o_mem_we                <= 1'b0;
      o_busy                  <= 1'b0;
      o_error                 <= 1'b0;
    end else begin
      W          <= 1'b0;
      Sel_outbus <= '0;
      Sel_DW     <= '0;
      unique case (state_q)
        StFetch: begin
          if (i_instr_valid) begin
            op_q    <= i_instruccion[IW-1 -: 3];
            fn_q    <= i_instruccion[2:0];
            Sel_reg <= i_instruccion[2*REG_BITS-1:0];
            o_busy  <= 1'b1;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          cnt_q <= '0;
          unique case (op_q)
            3'b001: begin
              state_q    <= StMem;
              o_mem_req  <= 1'b1;
              o_mem_we   <= 1'b0;
              Sel_DW     <= 3'b100;
              Sel_outbus <= 2'd2;
            end
            3'b010: begin
              state_q    <= StMem;
              o_mem_req  <= 1'b1;
              o_mem_we   <= 1'b1;
              Sel_DW     <= 3'b010;
              Sel_outbus <= 2'd1;
            end
            3'b011: begin
              state_q    <= StMem;
              o_mem_req  <= 1'b1;
              o_mem_we   <= 1'b1;
              Sel_DW     <= 3'b010;
              Sel_outbus <= 2'd3;
            end
            3'b000: begin
              state_q    <= StExec;
              W          <= 1'b1;
              Sel_DW     <= 3'b001;
              Sel_outbus <= 2'd1;
            end
            3'b100: begin
              state_q    <= StExec;
              W          <= 1'b1;
              Sel_DW     <= 3'b001;
              Sel_outbus <= 2'd3;
            end
            3'b101: begin
              state_q    <= StExec;
              Sel_op     <= fn_q;
              W          <= 1'b1;
              Sel_DW     <= 3'b001;
              Sel_outbus <= 2'd0;
            end
            default: state_q <= StExec;
          endcase
        end
        StExec: begin
          state_q <= StFetch;
          o_busy  <= 1'b0;
          Sel_op  <= '0;
          o_direccion_instruccion <= (op_q == 3'b110 && taken) ? ADDR_W'(Rx) : pc_inc;
        end
        StMem: begin
          // Ack is tested first so an ack in the final allowed cycle still completes cleanly.
          if (i_mem_ack || cnt_q == CntLast) begin
            state_q                 <= StFetch;
            o_busy                  <= 1'b0;
            o_mem_req               <= 1'b0;
            o_mem_we                <= 1'b0;
            cnt_q                   <= '0;
            o_direccion_instruccion <= pc_inc;
            if (i_mem_ack) begin
              if (op_q == 3'b001) begin
                W          <= 1'b1;
                Sel_DW     <= 3'b100;
                Sel_outbus <= 2'd2;
              end
            end else begin
              o_error <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_q + CntW'(1);
            Sel_DW     <= Sel_DW;
            Sel_outbus <= Sel_outbus;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_control_micro_mc.sv
// Self-checking bench for control_micro_mc: directed scenarios plus randomized instructions
// checked against an instruction-level reference model.
module tb_control_micro_mc;

  localparam int unsigned MemTimeout = 15;

  logic       clk;
  logic       rst;
  logic [8:0] i_instruccion;
  logic       i_instr_valid;
  logic [7:0] Rx;
  logic [2:0] Ban;
  logic       i_mem_ack;
  logic [2:0] Sel_op;
  logic [5:0] Sel_reg;
  logic       W;
  logic [1:0] Sel_outbus;
  logic [2:0] Sel_DW;
  logic       o_mem_req;
  logic       o_mem_we;
  logic [7:0] o_direccion_instruccion;
  logic       o_busy;
  logic       o_error;

  control_micro_mc #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .REG_BITS   (3),
    .MEM_TIMEOUT(MemTimeout),
    .RESET_PC   (0)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_instruccion          (i_instruccion),
    .i_instr_valid          (i_instr_valid),
    .Rx                     (Rx),
    .Ban                    (Ban),
    .i_mem_ack              (i_mem_ack),
    .Sel_op                 (Sel_op),
    .Sel_reg                (Sel_reg),
    .W                      (W),
    .Sel_outbus             (Sel_outbus),
    .Sel_DW                 (Sel_DW),
    .o_mem_req              (o_mem_req),
    .o_mem_we               (o_mem_we),
    .o_direccion_instruccion(o_direccion_instruccion),
    .o_busy                 (o_busy),
    .o_error                (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] model_pc;
  bit         model_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] exp_bus(input logic [2:0] op);
    case (op)
      3'b000, 3'b010: return 2'd1;
      3'b001:         return 2'd2;
      3'b011, 3'b100: return 2'd3;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_dw(input logic [2:0] op);
    case (op)
      3'b000, 3'b100, 3'b101: return 3'b001;
      3'b001:                 return 3'b100;
      3'b010, 3'b011:         return 3'b010;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic bit jump_taken(input logic [2:0] c, input logic [2:0] flags);
    bit n, cy, z;
    n = flags[2]; cy = flags[1]; z = flags[0];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return cy;
      3'd4:    return !cy;
      3'd5:    return n;
      3'd6:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction from a FETCH negedge to the next FETCH negedge.
  // ack_at: MEM cycle (1-based) in which ack is raised; 0 or > timeout means never.
  task automatic run_instr(input logic [8:0] ins, input int ack_at);
    logic [2:0] op, fn;
    int         n;
    bit         acked;
    op = ins[8:6];
    fn = ins[2:0];
    chk("fetch_busy", o_busy, 0);
    chk("fetch_pc", o_direccion_instruccion, model_pc);
    i_instruccion = ins;
    i_instr_valid = 1'b1;
    step();
    i_instr_valid = 1'b0;
    i_instruccion = 9'($urandom);
    chk("dec_busy", o_busy, 1);
    chk("dec_sel_reg", Sel_reg, ins[5:0]);
    chk("dec_w", W, 0);
    step();
    if (op inside {3'b001, 3'b010, 3'b011}) begin
      n = 0;
      acked = (ack_at >= 1) && (ack_at <= int'(MemTimeout));
      while (o_mem_req === 1'b1 && n < 40) begin
        n++;
        chk("mem_we", o_mem_we, op != 3'b001);
        chk("mem_dw", Sel_DW, exp_dw(op));
        chk("mem_bus", Sel_outbus, exp_bus(op));
        chk("mem_w_wait", W, 0);
        i_mem_ack = (n == ack_at);
        step();
        i_mem_ack = 1'b0;
      end
      chk("mem_cycles", n, acked ? ack_at : int'(MemTimeout));
      chk("mem_req_drop", o_mem_req, 0);
      chk("mem_w", W, (op == 3'b001) && acked);
      if (!acked) model_err = 1'b1;
      model_pc = model_pc + 8'd1;
    end else begin
      chk("exec_w", W, op inside {3'b000, 3'b100, 3'b101});
      chk("exec_bus", Sel_outbus, exp_bus(op));
      chk("exec_dw", Sel_DW, exp_dw(op));
      chk("exec_sel_op", Sel_op, (op == 3'b101) ? fn : 3'b000);
      chk("exec_req", o_mem_req, 0);
      if (op == 3'b110 && jump_taken(fn, Ban)) model_pc = Rx;
      else model_pc = model_pc + 8'd1;
      step();
      chk("done_w", W, 0);
    end
    chk("done_busy", o_busy, 0);
    chk("done_pc", o_direccion_instruccion, model_pc);
    chk("done_err", o_error, model_err);
  endtask

  initial begin
    rst = 1'b0;
    i_instruccion = '0;
    i_instr_valid = 1'b0;
    Rx = '0;
    Ban = '0;
    i_mem_ack = 1'b0;
    model_pc = 8'h00;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("rst_pc", o_direccion_instruccion, 8'h00);
    chk("rst_busy", o_busy, 0);
    chk("rst_w", W, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_err", o_error, 0);
    chk("rst_sel_reg", Sel_reg, 0);
    chk("rst_bus", Sel_outbus, 0);
    chk("rst_dw", Sel_DW, 0);
    chk("rst_sel_op", Sel_op, 0);

    run_instr(9'b000_001_100, 0);
    run_instr(9'b001_010_001, 2);
    run_instr(9'b011_111_110, 0);

    // Idle FETCH with stray acks: PC must hold.
    i_mem_ack = 1'b1;
    repeat (3) step();
    i_mem_ack = 1'b0;
    chk("idle_pc", o_direccion_instruccion, model_pc);
    chk("idle_req", o_mem_req, 0);
    chk("idle_err_sticky", o_error, 1);

    Rx = 8'h40;
    Ban = 3'b001;
    run_instr(9'b110_100_001, 0);
    Ban = 3'b000;
    run_instr(9'b110_100_001, 0);
    Ban = 3'b111;
    run_instr(9'b110_100_111, 0);
    run_instr(9'b101_011_010, 0);
    run_instr(9'b100_010_110, 0);

    Rx = 8'hFF;
    Ban = 3'b000;
    run_instr(9'b110_000_000, 0);
    run_instr(9'b111_100_001, 0);

    // Reset while waiting in MEM.
    i_instruccion = 9'b010_001_010;
    i_instr_valid = 1'b1;
    step();
    i_instr_valid = 1'b0;
    step();
    chk("pre_rst_req", o_mem_req, 1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_req", o_mem_req, 0);
    chk("arst_w", W, 0);
    chk("arst_err", o_error, 0);
    chk("arst_pc", o_direccion_instruccion, 8'h00);
    chk("arst_busy", o_busy, 0);
    chk("arst_dw", Sel_DW, 0);
    @(negedge clk);
    rst = 1'b1;
    model_pc = 8'h00;
    model_err = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      Rx = 8'($urandom);
      Ban = 3'($urandom);
      run_instr(9'($urandom), int'($urandom_range(0, 18)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
